cpu_step_controller: RTL and testbench
======================================

# cpu_step_controller

Clock-enable and reset sequencer for the tiny RISC-V processor. It is the successor to the fixed slow-clock divider. It generates a single-cycle `o_Clk_En` strobe in the `i_Clk` domain instead of a derived clock. The strobe supports halt, full-speed, runtime-programmable divided, and debounced single-step modes, plus a stretched processor reset and an executed-cycle counter. It sits between the board switches/buttons and the processor core in the top level.

## Interface
- `c_DIV_BITS`, 21: width of the runtime divisor `i_Div`.
- `c_DEBOUNCE_CYCLES`, 250000: consecutive stable cycles needed to accept a new button level (≥1).
- `c_RST_HOLD_CYCLES`, 16: cycles `o_RstN` stays low after `i_Rst` deasserts (≥1).

Ports:
- `i_Clk`  in  1  system clock; the only clock.
- `i_Rst`  in  1  reset, synchronous, active-high.
- `i_Mode`  in  2  run mode: 00 halt, 01 full, 10 divided, 11 step; asynchronous switches.
- `i_Div`  in  c_DIV_BITS  divided-mode period minus one; quasi-static.
- `i_Step_Btn`  in  1  raw step button, active-high, asynchronous, bouncy.
- `o_Clk_En`  out  1  processor clock enable, registered.
- `o_RstN`  out  1  processor reset, active-low, registered.
- `o_Step_Count`  out  32  number of enables issued since reset.

## Operation
- Synchronizers: `i_Mode` and `i_Step_Btn` each pass through a 2-FF synchronizer. The effective mode is the synchronized value.
- Debounce:
  - A counter compares the synced button against a debounced level `btn_db`.
  - While they differ, the counter increments; when they are equal, it clears.
  - On reaching c_DEBOUNCE_CYCLES, `btn_db` takes the synced value and the counter clears.
  - A rising edge of `btn_db` (0→1) produces a one-cycle `step_req`.
- State machine:
  - RESET: entered while `i_Rst`=1. `o_RstN`=0 and `o_Clk_En`=1 every cycle, so the core's synchronous reset is clocked. Hold counter is cleared.
  - HOLD: entered on `i_Rst` deassert. `o_RstN`=0 and `o_Clk_En`=1 for c_RST_HOLD_CYCLES cycles, then go to RUN.
  - RUN: `o_RstN`=1; `o_Clk_En` is decided by mode:
    - 00 (halt): `o_Clk_En`=0; the divider counter holds at 0.
    - 01 (full): `o_Clk_En`=1 every cycle.
    - 10 (divided): `div_cnt` counts up each cycle. When `div_cnt` ≥ `i_Div`, `o_Clk_En`=1 next cycle and `div_cnt` wraps to 0. `i_Div`=0 is equivalent to full speed. A period is therefore `i_Div`+1 cycles.
    - 11 (step): `o_Clk_En`=1 for exactly one cycle per `step_req`. Requests arriving in other modes are dropped, not queued.
- Mode change: any change of the effective mode clears `div_cnt` to 0 in the same cycle. The first divided-mode enable follows `i_Div`+1 cycles after the change.
- `o_Step_Count`: increments in every cycle where `o_Clk_En`=1 and the state is RUN. It wraps from 0xFFFFFFFF to 0. HOLD and RESET enables are not counted.
- Reset mid-operation: `i_Rst` asserted in any state forces RESET on the next edge. It clears all counters, `btn_db`, and synchronizers. A button held through reset does not produce a step on release of reset; it needs a release and a new press.

## Timing
- Reset values:
  - `o_RstN`=0, `o_Clk_En`=1, `o_Step_Count`=0.
  - `btn_db`=0, `div_cnt`=0, debounce counter=0.
- `o_RstN` rises exactly c_RST_HOLD_CYCLES+1 edges after the first edge sampling `i_Rst`=0.
- Mode latency: 2 cycles of synchronizer plus 1 registered output. A mode change shows on `o_Clk_En` 3 edges after the switch is sampled.
- Button latency: a clean rising edge on `i_Step_Btn` produces `o_Clk_En` high exactly c_DEBOUNCE_CYCLES+4 edges after first sampling 1. Breakdown: 2 sync, c_DEBOUNCE_CYCLES debounce, 1 edge detect, 1 output register.
- Glitches shorter than c_DEBOUNCE_CYCLES cycles produce no step.
- `o_Clk_En` is never high for 2 consecutive cycles in step mode.
- `o_Step_Count` updates on the same edge that `o_Clk_En` is registered high. It reflects the count including that enable.

## Test plan
Bench parameters: c_DEBOUNCE_CYCLES=4, c_RST_HOLD_CYCLES=3.
- Reset release: hold `i_Rst`=1 for 5 cycles, then release with mode 01.
  - Expected: `o_RstN`=0 with `o_Clk_En`=1 through 4 edges; `o_RstN`=1 thereafter.
  - Expected: `o_Clk_En`=1 every cycle; `o_Step_Count` increments by 1 per cycle starting from 0.
- Divided mode: mode 10, `i_Div`=3, run 40 cycles.
  - Expected: exactly 10 `o_Clk_En` pulses, each spaced 4 cycles apart; `o_Step_Count`=10.
- Divided mode, runtime divisor change: change `i_Div` 7→1 while `div_cnt`=5.
  - Expected: an enable on the next edge, then an enable every 2 cycles.
- Step mode with bounce: mode 11; toggle the button 1-0-1-0 at 1-cycle spacing, then hold 1 for 10 cycles, then release.
  - Expected: exactly one `o_Clk_En` pulse, 8 edges after the start of the stable high; `o_Step_Count`=1.
- Halt and mode switching: mode 00 with 3 button presses.
  - Expected: `o_Clk_En`=0 throughout; `o_Step_Count` unchanged.
  - Then switch to 11 with no new press: expected no pulse (presses are not queued).
- Counter wrap: force `o_Step_Count` to 0xFFFFFFFE in mode 01.
  - Expected: reads 0xFFFFFFFF, then 0x00000000.
- Reset mid-run: assert `i_Rst` during mode 10 at `div_cnt`=2.
  - Expected: next edge gives `o_RstN`=0 and `o_Step_Count`=0; after release, the hold sequence repeats.

Source files
------------

// File: rtl/cpu_step_controller.sv
// Clock-enable and reset sequencer for the processor core: produces a one-cycle
// o_Clk_En strobe (halt/full/divided/debounced single-step) plus a stretched core reset.
module cpu_step_controller #(
    parameter int c_DIV_BITS        = 21,
    parameter int c_DEBOUNCE_CYCLES = 250000,
    parameter int c_RST_HOLD_CYCLES = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [1:0]            i_Mode,
    input  logic [c_DIV_BITS-1:0] i_Div,
    input  logic                  i_Step_Btn,
    output logic                  o_Clk_En,
    output logic                  o_RstN,
    output logic [31:0]           o_Step_Count
);

    localparam int DB_W   = $clog2(c_DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(c_RST_HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(c_DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(c_RST_HOLD_CYCLES);

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_FULL = 2'b01,
        MODE_DIV  = 2'b10,
        MODE_STEP = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_HOLD,
        ST_RUN
    } state_t;

    logic [1:0]            mode_meta, mode_sync, mode_prev;
    logic                  btn_meta, btn_sync;
    logic [1:0]            fill;
    logic                  armed;
    logic [DB_W-1:0]       db_cnt;
    logic                  btn_db, btn_db_d, step_req;
    state_t                state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [c_DIV_BITS-1:0] div_cnt, div_next;
    logic [31:0]           step_cnt;
    logic                  run_en;
    mode_t                 mode;
    logic                  mode_changed;

    assign mode         = mode_t'(mode_sync);
    assign mode_changed = (mode_sync != mode_prev);
    assign o_Step_Count = step_cnt;

    // Synchronizers. `armed` only sets once a genuine low button level has been seen
    // after reset, so a button held through reset cannot produce a step.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mode_meta <= '0;
            mode_sync <= '0;
            mode_prev <= '0;
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            fill      <= '0;
            armed     <= 1'b0;
        end else begin
            mode_meta <= i_Mode;
            mode_sync <= mode_meta;
            mode_prev <= mode_sync;
            btn_meta  <= i_Step_Btn;
            btn_sync  <= btn_meta;
            fill      <= {fill[0], 1'b1};
            armed     <= armed | (fill[1] & ~btn_sync);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
            step_req <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            step_req <= btn_db & ~btn_db_d & armed;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // RUN-state enable decision; divided mode restarts its period on any mode change.
    // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        run_en   = 1'b0;
        div_next = '0;
        unique case (mode)
            MODE_HALT: run_en = 1'b0;
            MODE_FULL: run_en = 1'b1;
            MODE_DIV: begin
                if (mode_changed) begin
                    div_next = '0;
                end else if (div_cnt >= i_Div) begin
                    run_en   = 1'b1;
                    div_next = '0;
                end else begin
                    div_next = div_cnt + c_DIV_BITS'(1);
                end
            end
            MODE_STEP: run_en = step_req;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= ST_RESET;
            hold_cnt <= '0;
            div_cnt  <= '0;
            step_cnt <= '0;
            o_RstN   <= 1'b0;
            o_Clk_En <= 1'b1;
        end else begin
            unique case (state)
                ST_RESET: begin
                    state    <= ST_HOLD;
                    hold_cnt <= '0;
                    div_cnt  <= '0;
                    o_RstN   <= 1'b0;
                    o_Clk_En <= 1'b1;
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_RUN;
                        o_RstN   <= 1'b1;
                        o_Clk_En <= run_en;
                        div_cnt  <= div_next;
                        step_cnt <= step_cnt + 32'(run_en);
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        div_cnt  <= '0;
                        o_RstN   <= 1'b0;
                        o_Clk_En <= 1'b1;
                    end
                end
                ST_RUN: begin
                    o_RstN   <= 1'b1;
                    o_Clk_En <= run_en;
                    div_cnt  <= div_next;
                    step_cnt <= step_cnt + 32'(run_en);
                end
                default: state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with short debounce and reset-hold windows.
module tb_cpu_step_controller;

    localparam int DIV_BITS = 21;

    logic                clk;
    logic                rst;
    logic [1:0]          mode;
    logic [DIV_BITS-1:0] div;
    logic                btn;
    logic                clk_en;
    logic                rst_n;
    logic [31:0]         step_count;

    int errors = 0;
    int checks = 0;

    cpu_step_controller #(
        .c_DIV_BITS       (DIV_BITS),
        .c_DEBOUNCE_CYCLES(4),
        .c_RST_HOLD_CYCLES(3)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Mode      (mode),
        .i_Div       (div),
        .i_Step_Btn  (btn),
        .o_Clk_En    (clk_en),
        .o_RstN      (rst_n),
        .o_Step_Count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int last;

        // Reset release into full speed
        rst = 1'b1; mode = 2'b01; div = '0; btn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_rstn", 32'(rst_n), 32'd0);
            check("rst_en", 32'(clk_en), 32'd1);
            check("rst_cnt", step_count, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_rstn", 32'(rst_n), 32'd0);
            check("hold_en", 32'(clk_en), 32'd1);
            check("hold_cnt", step_count, 32'd0);
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("full_rstn", 32'(rst_n), 32'd1);
            check("full_en", 32'(clk_en), 32'd1);
            check("full_cnt", step_count, 32'(i));
        end

        // Divided mode, i_Div=3, from a fresh reset
        rst = 1'b1; mode = 2'b10; div = 21'd3;
        repeat (2) tick();
        check("div_rst_cnt", step_count, 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        check("div_hold_rstn", 32'(rst_n), 32'd0);
        pulses = 0;
        last = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("div_en", 32'(clk_en), 32'((k % 4) == 0));
            if (clk_en) begin
                check("div_gap", 32'(k - last), 32'd4);
                last = k;
                pulses++;
            end
        end
        check("div_pulses", 32'(pulses), 32'd10);
        check("div_cnt", step_count, 32'd10);

        // Runtime divisor change 7 -> 1 with div_cnt at 5
        div = 21'd7;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("div7_en", 32'(clk_en), 32'd0);
        end
        div = 21'd1;
        tick();
        check("div1_first", 32'(clk_en), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("div1_en", 32'(clk_en), 32'((k % 2) == 0));
        end
        check("div1_cnt", step_count, 32'd14);

        // Step mode with a bouncy press; one divided enable still lands in the switch-over
        mode = 2'b11;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("step_idle_en", 32'(clk_en), 32'd0);
        end
        check("step_base_cnt", step_count, 32'd15);
        for (int k = 0; k < 4; k++) begin
            btn = (k % 2 == 0);
            tick();
            check("bounce_en", 32'(clk_en), 32'd0);
        end
        btn = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check("step_en", 32'(clk_en), 32'(t == 8));
        end
        btn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("step_release_en", 32'(clk_en), 32'd0);
        end
        check("step_cnt", step_count, 32'd16);

        // Halt drops presses; switching to step afterwards must not replay them
        mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("halt_settle_en", 32'(clk_en), 32'd0);
        end
        for (int p = 0; p < 3; p++) begin
            btn = 1'b1;
            for (int k = 0; k < 6; k++) begin
                tick();
                check("halt_press_en", 32'(clk_en), 32'd0);
            end
            btn = 1'b0;
            for (int k = 0; k < 6; k++) begin
                tick();
                check("halt_rel_en", 32'(clk_en), 32'd0);
            end
        end
        check("halt_cnt", step_count, 32'd16);
        mode = 2'b11;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("no_queue_en", 32'(clk_en), 32'd0);
        end
        check("no_queue_cnt", step_count, 32'd16);

        // Counter wrap in full mode
        mode = 2'b01;
        repeat (2) tick();
        tick();
        check("wrap_pre_en", 32'(clk_en), 32'd1);
        check("wrap_pre_cnt", step_count, 32'd17);
        dut.step_cnt = 32'hFFFF_FFFE;
        tick();
        check("wrap_ff", step_count, 32'hFFFF_FFFF);
        tick();
        check("wrap_zero", step_count, 32'h0000_0000);
        tick();
        check("wrap_one", step_count, 32'h0000_0001);

        // Reset mid-run in divided mode at div_cnt=2, button held through reset
        mode = 2'b10; div = 21'd3;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("mid_en", 32'(clk_en), 32'(k <= 2));
        end
        check("mid_cnt", step_count, 32'd3);
        rst = 1'b1; btn = 1'b1;
        tick();
        check("mid_rst_rstn", 32'(rst_n), 32'd0);
        check("mid_rst_en", 32'(clk_en), 32'd1);
        check("mid_rst_cnt", step_count, 32'd0);
        tick();
        mode = 2'b11;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rehold_rstn", 32'(rst_n), 32'd0);
            check("rehold_en", 32'(clk_en), 32'd1);
        end
        tick();
        check("rerun_rstn", 32'(rst_n), 32'd1);
        check("rerun_en", 32'(clk_en), 32'd0);
        check("rerun_cnt", step_count, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("held_btn_en", 32'(clk_en), 32'd0);
        end
        btn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("held_rel_en", 32'(clk_en), 32'd0);
        end
        btn = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check("repress_en", 32'(clk_en), 32'(t == 8));
        end
        btn = 1'b0;
        tick();
        check("repress_cnt", step_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
